ysyx_25060170_pipe_stage_reg: RTL

Parametrised inter-stage pipeline register with a valid/ready handshake, replacing the fixed-field, stall/flush-style stage registers between IF/ID/EX/LS/WB. It carries an opaque payload of `DATA_W` bits, supports full-throughput back-pressure through an optional skid entry, squashes its contents on flush, and counts downstream stall cycles for performance analysis. One instance sits at each stage boundary; the decode/execute boundary packs its control and operand fields into `in_data`.

---
 rtl/ysyx_25060170_pipe_stage_reg.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ysyx_25060170_pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and a saturating stall counter.
// Define YSYX_25060170_PIPE_SKID_EN to add a skid entry and a registered in_ready.
module ysyx_25060170_pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] main_q;
  logic              acc;
  logic              pop;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

`ifdef YSYX_25060170_PIPE_SKID_EN
  logic [DATA_W-1:0] skid_q;

  // Decoded straight from the state flop so upstream never sees out_ready combinationally.
  assign in_ready = (state_q != ST_SKID);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_q  <= in_data;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (acc && pop) begin
            main_q <= in_data;
          end else if (acc) begin
            skid_q  <= in_data;
            state_q <= ST_SKID;
          end else if (pop) begin
            main_q  <= '0;
            state_q <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (pop) begin
            main_q  <= skid_q;
            skid_q  <= '0;
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end
      endcase
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;

  // Without a skid entry, acceptance while FULL always coincides with a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else if (flush) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            main_q  <= in_data;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (acc && pop) begin
            main_q <= in_data;
          end else if (pop) begin
            main_q  <= '0;
            state_q <= ST_EMPTY;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          main_q  <= '0;
        end
      endcase
    end
  end
`endif

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
